// File: rtl/uart_pkg.sv
// Shared types and helpers for the oversampling UART receive path.
// States, parity modes and the baud divider computation.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2,
    DONE,
    BRK_WAIT
  } rx_state_e;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_EVEN,
    PAR_ODD
  } parity_e;

  // Clocks per oversample tick, never below one.
  function automatic int uart_div(
    input int clk_hz,
    input int baud,
    input int ovs
  );
    int d;
    d = clk_hz / (baud * ovs);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick divider with synchronous restart.
// Shared by the receive and transmit paths.
module uart_baud_tick #(
  parameter int DIV = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic restart_i,
  output logic tick_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == CW'(DIV - 1));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart_i || tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver with majority vote and output register.
// Optional break detection is built when UART_RX_BREAK_EN is defined.
module uart_rx_ovs
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 res,
  input  logic                 en,
  input  logic                 rx,
  input  logic [1:0]           parity_mode,
  input  logic                 two_stop,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
`ifdef UART_RX_BREAK_EN
  ,
  output logic                 break_det
`endif
);

  localparam int DIV = uart_div(CLK_HZ, BAUD_RATE, OVERSAMPLE);
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int BCW = 4;
  localparam logic [SW-1:0] S_LO  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_MID = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] S_HI  = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] S_END = SW'(OVERSAMPLE - 1);

  rx_state_e            state_q, state_d;
  parity_e              par_q, par_d;
  logic                 two_q, two_d;
  logic                 s1_q, s2_q;
  logic [SW-1:0]        scnt_q, scnt_d;
  logic [1:0]           v_q, v_d;
  logic [BCW-1:0]       bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 perr_o_q, perr_o_d;
  logic                 ferr_o_q, ferr_o_d;
  logic                 ovr_q, ovr_d;
  logic                 restart, tick, dec, maj, load;
`ifdef UART_RX_BREAK_EN
  logic                 zero_q, zero_d;
  logic                 brk;
`endif

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk_i     (clk),
    .rst_ni    (res),
    .restart_i (restart),
    .tick_o    (tick)
  );

  assign dec = tick && (scnt_q == S_HI);
  assign maj = (v_q[0] & v_q[1]) | (v_q[0] & s2_q) | (v_q[1] & s2_q);

  always_comb begin
    state_d  = state_q;
    par_d    = par_q;
    two_d    = two_q;
    scnt_d   = scnt_q;
    v_d      = v_q;
    bcnt_d   = bcnt_q;
    sh_d     = sh_q;
    perr_d   = perr_q;
    ferr_d   = ferr_q;
    data_d   = data_q;
    valid_d  = valid_q;
    perr_o_d = perr_o_q;
    ferr_o_d = ferr_o_q;
    ovr_d    = ovr_q;
    restart  = 1'b0;
    load     = 1'b0;
`ifdef UART_RX_BREAK_EN
    zero_d   = zero_q;
    brk      = 1'b0;
`endif
    if (tick) begin
      scnt_d = (scnt_q == S_END) ? '0 : scnt_q + 1'b1;
      if (scnt_q == S_LO)  v_d[0] = s2_q;
      if (scnt_q == S_MID) v_d[1] = s2_q;
    end
    unique case (state_q)
      IDLE: begin
        if (!s2_q && en) begin
          state_d = START;
          restart = 1'b1;
          scnt_d  = '0;
          bcnt_d  = '0;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
          two_d   = two_stop;
          par_d   = (parity_mode == 2'd1) ? PAR_EVEN :
                    (parity_mode == 2'd2) ? PAR_ODD : PAR_NONE;
        end
      end
      START: if (dec) state_d = maj ? IDLE : DATA;
      DATA: begin
        if (dec) begin
          sh_d   = {maj, sh_q[DATA_BITS-1:1]};
          bcnt_d = bcnt_q + 1'b1;
          if (bcnt_q == BCW'(DATA_BITS - 1))
            state_d = (par_q == PAR_NONE) ? STOP1 : PARITY;
        end
      end
      PARITY: begin
        if (dec) begin
          perr_d  = (par_q == PAR_ODD) ? (^sh_q == maj)
                                       : (^sh_q != maj);
          state_d = STOP1;
        end
      end
      STOP1: begin
        if (dec) begin
          ferr_d  = ~maj;
          state_d = two_q ? STOP2 : DONE;
        end
      end
      STOP2: begin
        if (dec) begin
          ferr_d  = ferr_q | ~maj;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
`ifdef UART_RX_BREAK_EN
        if (zero_q) begin
          brk     = 1'b1;
          state_d = BRK_WAIT;
        end else begin
          load = 1'b1;
        end
`else
        load = 1'b1;
`endif
      end
      BRK_WAIT: if (s2_q) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
`ifdef UART_RX_BREAK_EN
    // Tracks "every bit through stop1 was 0"; stop2 is not part of it.
    if (restart) zero_d = 1'b1;
    else if (dec && (state_q == DATA || state_q == PARITY ||
                     state_q == STOP1))
      zero_d = zero_q & ~maj;
`endif
    if (load && (!valid_q || ready)) begin
      data_d   = sh_q;
      perr_o_d = perr_q;
      ferr_o_d = ferr_q;
      valid_d  = 1'b1;
      ovr_d    = 1'b0;
    end else if (load) begin
      ovr_d = 1'b1;
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!res) begin
      state_q  <= IDLE;
      par_q    <= PAR_NONE;
      two_q    <= 1'b0;
      s1_q     <= 1'b1;
      s2_q     <= 1'b1;
      scnt_q   <= '0;
      v_q      <= '0;
      bcnt_q   <= '0;
      sh_q     <= '0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      perr_o_q <= 1'b0;
      ferr_o_q <= 1'b0;
      ovr_q    <= 1'b0;
`ifdef UART_RX_BREAK_EN
      zero_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      par_q    <= par_d;
      two_q    <= two_d;
      s1_q     <= rx;
      s2_q     <= s1_q;
      scnt_q   <= scnt_d;
      v_q      <= v_d;
      bcnt_q   <= bcnt_d;
      sh_q     <= sh_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      perr_o_q <= perr_o_d;
      ferr_o_q <= ferr_o_d;
      ovr_q    <= ovr_d;
`ifdef UART_RX_BREAK_EN
      zero_q   <= zero_d;
`endif
    end
  end

  assign data       = data_q;
  assign valid      = valid_q;
  assign parity_err = perr_o_q;
  assign frame_err  = ferr_o_q;
  assign overrun    = ovr_q;
`ifdef UART_RX_BREAK_EN
  assign break_det  = brk;
`endif

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Scoreboard bench for uart_rx_ovs at 16 clocks per bit.
// Covers directed frames, glitch, overrun, stop errors, mid-frame reset and random frames.
module tb_uart_rx_ovs;

  localparam int BIT_CLKS = 16;

  logic       clk = 1'b0;
  logic       res = 1'b0;
  logic       en = 1'b1;
  logic       rx = 1'b1;
  logic [1:0] parity_mode = 2'd0;
  logic       two_stop = 1'b0;
  logic       ready = 1'b1;
  logic [7:0] data;
  logic       valid, parity_err, frame_err, overrun;
`ifdef UART_RX_BREAK_EN
  logic       break_det;
  int         brk_cnt = 0;
`endif

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  uart_rx_ovs #(
    .CLK_HZ     (16_000_000),
    .BAUD_RATE  (1_000_000),
    .OVERSAMPLE (16),
    .DATA_BITS  (8)
  ) dut (
    .clk         (clk),
    .res         (res),
    .en          (en),
    .rx          (rx),
    .parity_mode (parity_mode),
    .two_stop    (two_stop),
    .data        (data),
    .valid       (valid),
    .ready       (ready),
    .parity_err  (parity_err),
    .frame_err   (frame_err),
    .overrun     (overrun)
`ifdef UART_RX_BREAK_EN
    ,
    .break_det   (break_det)
`endif
  );

  always #5 clk = ~clk;

`ifdef UART_RX_BREAK_EN
  always @(negedge clk) if (break_det === 1'b1) brk_cnt++;
`endif

  // Reference: word plus flags derived from the frame-level rules.
  function automatic exp_t model(input logic [7:0] d, input logic [1:0] pm,
                                 input logic pb, input logic ts,
                                 input logic s1, input logic s2);
    exp_t e;
    e.d  = d;
    e.pe = (pm == 2'd1) ? ((^d) != pb) :
           (pm == 2'd2) ? ((^d) == pb) : 1'b0;
    e.fe = !s1 || (ts && !s2);
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bit_out(input logic b);
    rx = b;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic gap(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d, input logic [1:0] pm,
                      input logic pb, input logic ts, input logic s1,
                      input logic s2, input bit push);
    parity_mode = pm;
    two_stop    = ts;
    if (push) q.push_back(model(d, pm, pb, ts, s1, s2));
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(d[i]);
    if (pm == 2'd1 || pm == 2'd2) bit_out(pb);
    bit_out(s1);
    if (ts) bit_out(s2);
    rx = 1'b1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", q.size(), 0);
  endtask

  // Monitor: sample mid-cycle, pop on every accepted word.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (res && valid && ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word: got %0h expected none", data);
        end else begin
          e = q.pop_front();
          if (data !== e.d || parity_err !== e.pe || frame_err !== e.fe) begin
            errors++;
            $display("FAIL word: got %0h pe=%0b fe=%0b expected %0h pe=%0b fe=%0b",
                     data, parity_err, frame_err, e.d, e.pe, e.fe);
          end
        end
      end
    end
  end

  initial begin
    #3_000_000;
    errors++;
    $display("FAIL timeout: got no finish expected finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    logic [7:0] d;
    logic [1:0] pm;
    logic       pb, ts, s1, s2;
    repeat (3) @(negedge clk);
    chk("rst_valid", valid, 0);
    chk("rst_data", data, 0);
    chk("rst_perr", parity_err, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovr", overrun, 0);
`ifdef UART_RX_BREAK_EN
    chk("rst_brk", break_det, 0);
`endif
    res = 1'b1;
    gap(10);

    send(8'hA5, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1);
    gap(20);
    drain();

    send(8'h03, 2'd1, 1'b1, 1'b0, 1'b1, 1'b1, 1);
    gap(20);
    send(8'h03, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1);
    gap(20);
    send(8'hB6, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1);
    gap(20);
    drain();

    rx = 1'b0;
    repeat (4) @(negedge clk);
    gap(40);
    chk("glitch_valid", valid, 0);
    send(8'h5A, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1);
    gap(20);
    drain();

    en = 1'b0;
    send(8'h55, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 0);
    gap(20);
    chk("en_off_valid", valid, 0);
    en = 1'b1;

    ready = 1'b0;
    send(8'h11, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1);
    gap(20);
    send(8'h22, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 0);
    gap(20);
    chk("ovr_valid", valid, 1);
    chk("ovr_data", data, 8'h11);
    chk("ovr_flag", overrun, 1);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    @(negedge clk);
    chk("ack_valid", valid, 0);
    chk("ack_ovr", overrun, 0);
    chk("ack_data_hold", data, 8'h11);
    ready = 1'b1;
    drain();

    send(8'h3C, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1);
    gap(24);
    drain();

`ifdef UART_RX_BREAK_EN
    begin
      int b0;
      b0 = brk_cnt;
      parity_mode = 2'd0;
      two_stop    = 1'b0;
      rx = 1'b0;
      repeat (12 * BIT_CLKS) @(negedge clk);
      gap(40);
      chk("break_pulses", brk_cnt - b0, 1);
      chk("break_valid", valid, 0);
    end
    send(8'h7E, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1);
    gap(20);
`else
    send(8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1);
    gap(30);
    send(8'h7E, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1);
    gap(20);
`endif
    drain();

    parity_mode = 2'd0;
    two_stop    = 1'b0;
    bit_out(1'b0);
    for (int i = 0; i < 3; i++) bit_out(1'b0);
    rx = 1'b0;
    repeat (8) @(negedge clk);
    res = 1'b0;
    repeat (2) @(negedge clk);
    res = 1'b1;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 5; i++) bit_out(1'b1);
    gap(30);
    chk("rst_abort_valid", valid, 0);
    send(8'hC3, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1);
    gap(20);
    drain();

    for (int n = 0; n < 40; n++) begin
      d  = 8'($urandom);
      pm = 2'($urandom_range(0, 3));
      pb = 1'($urandom);
      ts = 1'($urandom);
      s1 = ($urandom_range(0, 3) != 0);
      s2 = ($urandom_range(0, 3) != 0);
`ifdef UART_RX_BREAK_EN
      if (d == 8'h00 && !s1 && (pb == 1'b0 || pm == 2'd0 || pm == 2'd3))
        d = 8'h01;
`endif
      send(d, pm, pb, ts, s1, s2, 1);
      gap(24 + int'($urandom_range(0, 10)));
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
